// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read handshake between the fetch unit and instruction memory.
interface if_fetch_unit_if;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;

    // Fetch unit side: issues the request, receives the word.
    modport master (
        output imem_read,
        output imem_address,
        input  imem_rdata,
        input  imem_resp
    );

    // Memory side: receives the request, returns the word.
    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_rdata,
        output imem_resp
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage of the pipelined LC-3b core.
// Owns the PC, drives the instruction-memory read handshake, buffers one word
// across a pipeline stall and squashes an in-flight read when a redirect arrives
// before the memory has answered.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [15:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [15:0]            inst_out,
    output logic [15:0]            pc_out,
    output logic                   ifid_load
);

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StSquash
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pend_pc_q, pend_pc_d;
    logic [15:0] buf_inst_q, buf_inst_d;

    logic        read_c;
    logic        load_c;
    logic [15:0] inst_c;

    // State register; reset abandons any outstanding read immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            pend_pc_q  <= 16'h0000;
            buf_inst_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    // Next-state and handshake/output decode; redirect outranks stall everywhere.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        buf_inst_d = buf_inst_q;
        read_c     = 1'b0;
        load_c     = 1'b0;
        inst_c     = imem.imem_rdata;

        unique case (state_q)
            StFetch: begin
                read_c = 1'b1;
                if (imem.imem_resp) begin
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else if (stall) begin
                        buf_inst_d = imem.imem_rdata;
                        state_d    = StHold;
                    end else begin
                        load_c = 1'b1;
                        pc_d   = pc_q + PC_STEP;
                    end
                end else if (redirect) begin
                    // Read is in flight at the old address; remember where to go.
                    pend_pc_d = redirect_pc;
                    state_d   = StSquash;
                end
            end
            StHold: begin
                inst_c = buf_inst_q;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = StFetch;
                end else if (!stall) begin
                    load_c  = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    state_d = StFetch;
                end
            end
            StSquash: begin
                // Keep the old request stable until memory completes it.
                read_c = 1'b1;
                if (imem.imem_resp) begin
                    pc_d    = redirect ? redirect_pc : pend_pc_q;
                    state_d = StFetch;
                end else if (redirect) begin
                    pend_pc_d = redirect_pc;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Outputs take their reset values as soon as reset goes low.
        if (!reset) begin
            read_c = 1'b0;
            load_c = 1'b0;
            inst_c = 16'h0000;
        end
    end

    assign imem.imem_read    = read_c;
    assign imem.imem_address = pc_q;
    assign inst_out          = inst_c;
    assign pc_out            = pc_q + PC_STEP;
    assign ifid_load         = load_c;

endmodule
